// File: rtl/line_follower_pkg.sv
// Shared constants for the line follower: position encoding, FSM state codes, sample validity.
// Pure definitions, no logic or flow control of its own.
`timescale 1ns/1ps
package line_follower_pkg;

    localparam int POS_W = 11;

    localparam logic [POS_W-1:0] POS_ERROR = 11'd1023;
    localparam logic [POS_W-1:0] POS_MIN   = 11'd1;
    localparam logic [POS_W-1:0] POS_MAX   = 11'd1000;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_TRACK  = 2'd1;
    localparam logic [1:0] ST_SEARCH = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    // 0 (sensor just out of reset) and everything above POS_MAX, including POS_ERROR, is unusable
    function automatic logic pos_valid(input logic [POS_W-1:0] p);
        return (p >= POS_MIN) && (p <= POS_MAX);
    endfunction

endpackage

// File: rtl/pwm_generator.sv
// Free-running PWM: duty loads only at counter wrap so each period is whole; output registered.
// Latency: new duty takes effect at the next period start; no backpressure.
`timescale 1ns/1ps
module pwm_generator #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] duty,
    output logic                pwm
);

    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic [PWM_BITS-1:0] duty_act_q, duty_act_d;
    logic                pwm_q, pwm_d;

    always_comb begin
        cnt_d      = cnt_q + PWM_BITS'(1);
        duty_act_d = (cnt_q == '1) ? duty : duty_act_q;
        // compare on next-state values so pwm_q lines up with cnt_q without a combinational output
        pwm_d      = (cnt_d < duty_act_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            duty_act_q <= '0;
            pwm_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            duty_act_q <= duty_act_d;
            pwm_q      <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/steering_controller.sv
// PD line-follower steering with lost-line search/stop FSM driving two PWM motor outputs.
// Latency: duties update 1 clk after a sample tick; PWM follows at next period; no backpressure.
`timescale 1ns/1ps
module steering_controller
    import line_follower_pkg::*;
#(
    parameter int PWM_BITS     = 8,
    parameter int SAMPLE_DIV   = 100000,
    parameter int SETPOINT     = 500,
    parameter int BASE_DUTY    = 160,
    parameter int KP_SHIFT     = 2,
    parameter int KD_SHIFT     = 1,
    parameter int SEARCH_DUTY  = 120,
    parameter int LOST_TIMEOUT = 50
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [POS_W-1:0]    position,
    output logic                pwm_left,
    output logic                pwm_right,
    output logic [PWM_BITS-1:0] duty_left,
    output logic [PWM_BITS-1:0] duty_right,
    output logic [1:0]          ctrl_state,
    output logic                lost
);

    localparam int DIV_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int LOST_W   = $clog2(LOST_TIMEOUT + 1);
    localparam int DUTY_MAX = (2 ** PWM_BITS) - 1;

    logic [DIV_W-1:0]    div_q, div_d;
    logic [1:0]          state_q, state_d;
    logic [PWM_BITS-1:0] duty_left_q, duty_left_d;
    logic [PWM_BITS-1:0] duty_right_q, duty_right_d;
    logic signed [11:0]  err_prev_q, err_prev_d;
    logic [LOST_W-1:0]   lost_cnt_q, lost_cnt_d;

    logic                tick;
    logic                sample_ok;
    logic signed [11:0]  err;
    logic signed [11:0]  err_ref;
    logic signed [12:0]  err_x, diff, p_term, d_term, corr;
    logic signed [15:0]  corr_x, left_raw, right_raw;
    logic [PWM_BITS-1:0] trk_left, trk_right;
    logic [PWM_BITS-1:0] srch_left, srch_right;
    logic [LOST_W-1:0]   lost_cnt_inc;

    function automatic logic [PWM_BITS-1:0] sat_duty(input logic signed [15:0] v);
        if (v < 16'sd0)
            return '0;
        else if (v > 16'(DUTY_MAX))
            return '1;
        else
            return v[PWM_BITS-1:0];
    endfunction

    assign tick      = (div_q == DIV_W'(SAMPLE_DIV - 1));
    assign sample_ok = pos_valid(position);

    always_comb begin
        div_d = tick ? '0 : div_q + DIV_W'(1);
    end

    // Outside TRACK the reference is the current error itself, so a (re)entry has no D kick
    always_comb begin
        err       = 12'($signed({1'b0, position}) - SETPOINT);
        err_ref   = (state_q == ST_TRACK) ? err_prev_q : err;
        err_x     = $signed({err[11], err});
        diff      = err_x - $signed({err_ref[11], err_ref});
        p_term    = err_x >>> KP_SHIFT;
        d_term    = diff >>> KD_SHIFT;
        corr      = p_term + d_term;
        corr_x    = $signed({{3{corr[12]}}, corr});
        left_raw  = 16'(BASE_DUTY) + corr_x;
        right_raw = 16'(BASE_DUTY) - corr_x;
        trk_left  = sat_duty(left_raw);
        trk_right = sat_duty(right_raw);
    end

    // Spin toward the side the line was last seen on; err_prev of 0 counts as right-of-centre
    always_comb begin
        srch_left  = err_prev_q[11] ? '0 : PWM_BITS'(SEARCH_DUTY);
        srch_right = err_prev_q[11] ? PWM_BITS'(SEARCH_DUTY) : '0;
    end

    assign lost_cnt_inc = lost_cnt_q + LOST_W'(1);

    always_comb begin
        state_d      = state_q;
        duty_left_d  = duty_left_q;
        duty_right_d = duty_right_q;
        err_prev_d   = err_prev_q;
        lost_cnt_d   = lost_cnt_q;

        if (!enable) begin
            state_d      = ST_IDLE;
            duty_left_d  = '0;
            duty_right_d = '0;
            lost_cnt_d   = '0;
        end else if (tick) begin
            if (sample_ok) begin
                state_d      = ST_TRACK;
                duty_left_d  = trk_left;
                duty_right_d = trk_right;
                err_prev_d   = err;
                lost_cnt_d   = '0;
            end else begin
                case (state_q)
                    ST_IDLE, ST_TRACK: begin
                        state_d      = ST_SEARCH;
                        duty_left_d  = srch_left;
                        duty_right_d = srch_right;
                        lost_cnt_d   = LOST_W'(1);
                    end
                    ST_SEARCH: begin
                        lost_cnt_d = lost_cnt_inc;
                        if (lost_cnt_inc == LOST_W'(LOST_TIMEOUT)) begin
                            state_d      = ST_STOP;
                            duty_left_d  = '0;
                            duty_right_d = '0;
                        end else begin
                            duty_left_d  = srch_left;
                            duty_right_d = srch_right;
                        end
                    end
                    default: begin
                        state_d      = ST_STOP;
                        duty_left_d  = '0;
                        duty_right_d = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q        <= '0;
            state_q      <= ST_IDLE;
            duty_left_q  <= '0;
            duty_right_q <= '0;
            err_prev_q   <= '0;
            lost_cnt_q   <= '0;
        end else begin
            div_q        <= div_d;
            state_q      <= state_d;
            duty_left_q  <= duty_left_d;
            duty_right_q <= duty_right_d;
            err_prev_q   <= err_prev_d;
            lost_cnt_q   <= lost_cnt_d;
        end
    end

    pwm_generator #(.PWM_BITS(PWM_BITS)) u_pwm_left (
        .clk   (clk),
        .rst_n (rst_n),
        .duty  (duty_left_q),
        .pwm   (pwm_left)
    );

    pwm_generator #(.PWM_BITS(PWM_BITS)) u_pwm_right (
        .clk   (clk),
        .rst_n (rst_n),
        .duty  (duty_right_q),
        .pwm   (pwm_right)
    );

    assign duty_left  = duty_left_q;
    assign duty_right = duty_right_q;
    assign ctrl_state = state_q;
    assign lost       = (state_q == ST_STOP);

endmodule

// File: tb/tb_steering_controller.sv
// Directed bench for steering_controller with a 10-cycle sample divider.
// Vector table for the control law and FSM, hand sequences for timing and PWM corners.
`timescale 1ns/1ps
module tb_steering_controller;

    localparam int SDIV = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [10:0] position = 11'd0;
    logic        pwm_left, pwm_right;
    logic [7:0]  duty_left, duty_right;
    logic [1:0]  ctrl_state;
    logic        lost;

    int n_vec = 0;
    int n_bad = 0;
    int cyc;

    steering_controller #(.SAMPLE_DIV(SDIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .position   (position),
        .pwm_left   (pwm_left),
        .pwm_right  (pwm_right),
        .duty_left  (duty_left),
        .duty_right (duty_right),
        .ctrl_state (ctrl_state),
        .lost       (lost)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic        en;
        logic [10:0] pos;
        int          ticks;
        int          l;
        int          r;
        int          st;
        logic        lst;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic en, input int pos, input int ticks,
                       input int l, input int r, input int st, input logic lst);
        vec_t v;
        v.en = en; v.pos = 11'(pos); v.ticks = ticks;
        v.l = l; v.r = r; v.st = st; v.lst = lst;
        vt.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input int l, input int r, input int st, input logic lst);
        chk({tag, " duty_left"},  32'(duty_left),  32'(l));
        chk({tag, " duty_right"}, 32'(duty_right), 32'(r));
        chk({tag, " ctrl_state"}, 32'(ctrl_state), 32'(st));
        chk({tag, " lost"},       32'(lost),       32'(lst));
    endtask

    task automatic step(input int n);
        repeat (n * SDIV) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        position = 11'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic count_period(input int change_at, input logic [10:0] newpos,
                                output int hl, output int hr);
        int guard = 0;
        while ((cyc % 256) != 0 && guard < 300) begin
            @(posedge clk);
            #1;
            guard++;
        end
        hl = 0;
        hr = 0;
        for (int i = 0; i < 256; i++) begin
            if (pwm_left === 1'b1)  hl++;
            if (pwm_right === 1'b1) hr++;
            if (i == change_at) position = newpos;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int hl, hr;

        // en, pos, ticks, left, right, state, lost
        add(1'b1,  500,  1, 160, 160, 1, 1'b0);
        add(1'b1,  750,  1, 255,   0, 1, 1'b0);
        add(1'b1,  750,  1, 222,  98, 1, 1'b0);
        add(1'b1, 1000,  1, 255,   0, 1, 1'b0);
        add(1'b1, 1000,  1, 255,  35, 1, 1'b0);
        add(1'b1,  500,  1,   0, 255, 1, 1'b0);
        add(1'b1,  500,  1, 160, 160, 1, 1'b0);
        add(1'b1,  700,  1, 255,  10, 1, 1'b0);
        add(1'b1,  700,  1, 210, 110, 1, 1'b0);
        add(1'b1,  750,  1, 247,  73, 1, 1'b0);
        add(1'b1,  750,  1, 222,  98, 1, 1'b0);
        add(1'b1, 1023,  1, 120,   0, 2, 1'b0);
        add(1'b1, 1023, 48, 120,   0, 2, 1'b0);
        add(1'b1, 1023,  1,   0,   0, 3, 1'b1);
        add(1'b1,  400,  1, 135, 185, 1, 1'b0);
        add(1'b1, 1001,  1,   0, 120, 2, 1'b0);
        add(1'b1,    0,  1,   0, 120, 2, 1'b0);
        add(1'b1,    1,  1,  35, 255, 1, 1'b0);
        add(1'b1,    1,  1,  35, 255, 1, 1'b0);
        add(1'b0,    1,  1,   0,   0, 0, 1'b0);
        add(1'b1,  600,  1, 185, 135, 1, 1'b0);

        // Outputs held at zero while in reset, even with a run request
        rst_n = 1'b0;
        enable = 1'b1;
        position = 11'd500;
        repeat (3) @(posedge clk);
        #1;
        chk_outs("reset", 0, 0, 0, 1'b0);
        chk("reset pwm_left",  32'(pwm_left),  32'd0);
        chk("reset pwm_right", 32'(pwm_right), 32'd0);

        do_reset();
        foreach (vt[i]) begin
            enable = vt[i].en;
            position = vt[i].pos;
            step(vt[i].ticks);
            chk_outs($sformatf("v%0d", i), vt[i].l, vt[i].r, vt[i].st, vt[i].lst);
        end

        // Duties hold until the tick edge; enable falling on the tick cycle forces IDLE
        position = 11'd750;
        repeat (SDIV - 1) @(posedge clk);
        #1;
        chk("pre_tick duty_left", 32'(duty_left), 32'd185);
        enable = 1'b0;
        @(posedge clk);
        #1;
        chk_outs("en_fall_on_tick", 0, 0, 0, 1'b0);

        // Invalid first sample after reset goes straight to SEARCH, left side
        do_reset();
        enable = 1'b1;
        position = 11'd0;
        step(1);
        chk_outs("reset_pos0", 120, 0, 2, 1'b0);
        step(1);
        chk_outs("reset_pos0_again", 120, 0, 2, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        enable = 1'b0;
        @(posedge clk);
        #1;
        chk_outs("en_drop_midperiod", 0, 0, 0, 1'b0);

        // PWM: whole periods only, duty change mid-period waits for the wrap
        do_reset();
        enable = 1'b1;
        position = 11'd500;
        count_period(-1, 11'd500, hl, hr);
        chk("pwm p0 left",  32'(hl), 32'd0);
        count_period(-1, 11'd500, hl, hr);
        chk("pwm p1 left",  32'(hl), 32'd160);
        chk("pwm p1 right", 32'(hr), 32'd160);
        count_period(90, 11'd750, hl, hr);
        chk("pwm p2 left",  32'(hl), 32'd160);
        chk("pwm p2 right", 32'(hr), 32'd160);
        chk("p2 end duty_left", 32'(duty_left), 32'd222);
        count_period(-1, 11'd750, hl, hr);
        chk("pwm p3 left",  32'(hl), 32'd222);
        chk("pwm p3 right", 32'(hr), 32'd98);

        // Async reset while pwm_left is high drops everything without waiting for a clock
        repeat (10) @(posedge clk);
        #1;
        chk("pwm_left before reset", 32'(pwm_left), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async rst pwm_left",  32'(pwm_left),  32'd0);
        chk("async rst pwm_right", 32'(pwm_right), 32'd0);
        chk_outs("async rst", 0, 0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/steering_controller.md
Name: steering_controller

Overview:
Consumes the registered 11-bit line position produced by the sensor front-end and drives the two drive motors.
- Samples the position at a fixed control rate.
- Computes a clamped PD correction around the line centre.
- Converts left/right duty into glitch-free PWM.
- Runs a lost-line recovery state machine (search, then stop).
- Sits between the sensor handler and the motor driver pins (Pmod H-bridge enable inputs).

Parameters:
- PWM_BITS, 8, PWM counter/duty width; duty full scale = 2^PWM_BITS-1.
- SAMPLE_DIV, 100000, clk cycles per control update (1 kHz at 100 MHz).
- SETPOINT, 500, position value meaning "line centred".
- BASE_DUTY, 160, forward duty applied to both wheels at zero error.
- KP_SHIFT, 2, P term = err >>> KP_SHIFT.
- KD_SHIFT, 1, D term = (err - err_prev) >>> KD_SHIFT.
- SEARCH_DUTY, 120, duty of the outer wheel while searching.
- LOST_TIMEOUT, 50, consecutive invalid samples before STOP.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- enable, in, 1, run request (board switch, already synchronised).
- position, in, 11, line position: 1..1000 valid, 1023 = sensor error code.
- pwm_left, out, 1, left motor PWM.
- pwm_right, out, 1, right motor PWM.
- duty_left, out, PWM_BITS, currently commanded left duty (debug/display).
- duty_right, out, PWM_BITS, currently commanded right duty.
- ctrl_state, out, 2, FSM state for LEDs.
- lost, out, 1, high in STOP.

Behaviour:
- Reset (async, rst_n=0):
  - FSM = IDLE.
  - All outputs 0: duties, pwm, lost.
  - Sample divider, lost counter and err_prev all 0.
- Sample tick:
  - 1-cycle pulse when the divider reaches SAMPLE_DIV-1; divider then wraps to 0.
  - The divider runs in all states.
- Valid sample: 1 <= position <= 1000. Anything else (0 after sensor reset, 1001..1023) is invalid.
- Error arithmetic:
  - err = position - SETPOINT, 12-bit signed.
  - corr = (err >>> KP_SHIFT) + ((err - err_prev) >>> KD_SHIFT), 13-bit signed, arithmetic shifts.
  - left = BASE_DUTY + corr, right = BASE_DUTY - corr; each saturated to [0, 2^PWM_BITS-1].
  - err_prev <= err on every valid tick in TRACK.
- FSM (transitions evaluated on tick only, except enable=0):
  - enable=0 in any state: IDLE next cycle, duties 0.
  - IDLE: duties 0. On tick with enable=1: valid sample -> TRACK (err_prev preloaded with err, so D=0 on the first update); invalid -> SEARCH.
  - TRACK: valid tick -> duties updated per the arithmetic above. Invalid tick -> SEARCH, lost counter = 1.
  - SEARCH: spin toward the last known side. If err_prev >= 0: left = SEARCH_DUTY, right = 0; otherwise mirrored.
    - Valid tick -> TRACK, err_prev preloaded (no D kick).
    - Invalid tick -> lost counter +1; when it reaches LOST_TIMEOUT -> STOP.
  - STOP: duties 0, lost=1. Valid tick -> TRACK, lost cleared, counter cleared.
- Latency: duty_left/duty_right update exactly 1 clk after the tick that sampled position.
- PWM:
  - Free-running PWM_BITS counter; pwm = (cnt < duty_active).
  - duty_active loads the commanded duty only when cnt = max, so no mid-period glitch.
  - duty 0 gives constant low; duty 255 gives high for 255 of 256 cycles.
- Simultaneous events: enable falling on a tick cycle -> IDLE wins. The position input is used only on tick cycles.
- Reset mid-operation: PWM outputs drop immediately (async), no partial period.

Decomposition:
- Package line_follower_pkg holds:
  - POS_ERROR = 1023, POS_MIN = 1, POS_MAX = 1000.
  - State encoding: IDLE = 0, TRACK = 1, SEARCH = 2, STOP = 3.
  - The shared position width (11).
- Sub-module pwm_generator (counter, period-aligned duty load, compare), instantiated twice.
- Control/FSM logic stays in steering_controller.

Test Plan (SAMPLE_DIV = 10 to shorten simulation):
- enable=1, position=500 steady -> TRACK; duty_left = duty_right = 160 one clk after the first tick; PWM high 160 of every 256 cycles.
- Steady position=750 (second and later ticks, D=0) -> corr = 62; left 222, right 98. Steady position=1000 -> left saturates at 255, right = 35.
- Step 500 -> 700 on consecutive ticks -> err = 200, D = 100, corr = 150; left 255 (sat), right 10. Next tick, same input -> corr = 50; left 210, right 110.
- Track at 750, then position=1023 -> SEARCH: left 120, right 0. After 50 invalid ticks -> STOP, lost=1, duties 0. Then position=400 -> TRACK, corr = -25: left 135, right 185.
- After reset, position=0 with enable=1 -> SEARCH with left 120 (err_prev = 0 counts as >= 0), no TRACK entry.
- Duty change mid-period -> pwm width changes only from the next counter wrap. Assert rst_n=0 mid-PWM-high -> pwm_left=0 the same cycle, all outputs 0.
